// File: rtl/input_conditioner.sv
// Synchronizes and debounces active-low buttons and switches, and latches press events for the CPU.
// Optional macro INPUT_COND_SW_DEBOUNCE_EN adds counter debouncers to the switch inputs.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] buttons,
  input  logic [9:0] switches,
  input  logic       ack,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [9:0] sw_sync,
  output logic [3:0] pending,
  output logic       irq,
  output logic [1:0] event_id
);

  localparam logic [15:0] DB_LIMIT = 16'(DEBOUNCE_CYCLES);

  logic [3:0]  btn_s1_q, btn_s2_q;
  logic [9:0]  sw_s1_q, sw_s2_q;
  logic [15:0] btn_cnt_q [4];
  logic [15:0] btn_cnt_d [4];
  logic [3:0]  btn_level_q, btn_level_d;
  logic [3:0]  btn_press_q, btn_press_d;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  ack_clr_s;
  logic [3:0]  btn_raw_s;

  // Two-flop synchronizers; button chains idle high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1_q <= 4'b1111;
      btn_s2_q <= 4'b1111;
      sw_s1_q  <= 10'b0;
      sw_s2_q  <= 10'b0;
    end else begin
      btn_s1_q <= buttons;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= switches;
      sw_s2_q  <= sw_s1_q;
    end
  end

  assign btn_raw_s = ~btn_s2_q;

  // Button debounce counters and level toggle.
  always_comb begin
    btn_level_d = btn_level_q;
    for (int i = 0; i < 4; i++) begin
      btn_cnt_d[i] = 16'd0;
      if (btn_raw_s[i] == btn_level_q[i]) begin
        btn_cnt_d[i] = 16'd0;
      end else if (btn_cnt_q[i] + 16'd1 == DB_LIMIT) begin
        btn_level_d[i] = ~btn_level_q[i];
        btn_cnt_d[i]   = 16'd0;
      end else begin
        btn_cnt_d[i] = btn_cnt_q[i] + 16'd1;
      end
    end
    btn_press_d = btn_level_d & ~btn_level_q;
  end

  // Acknowledge clears the bit currently reported; a same-cycle press re-sets it.
  always_comb begin
    if (ack && (pending_q != 4'b0000)) begin
      ack_clr_s = 4'b0001 << event_id;
    end else begin
      ack_clr_s = 4'b0000;
    end
    pending_d = (pending_q & ~ack_clr_s) | btn_press_q;
  end

  // Button level, press pulse and pending state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        btn_cnt_q[i] <= 16'd0;
      end
      btn_level_q <= 4'b0000;
      btn_press_q <= 4'b0000;
      pending_q   <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        btn_cnt_q[i] <= btn_cnt_d[i];
      end
      btn_level_q <= btn_level_d;
      btn_press_q <= btn_press_d;
      pending_q   <= pending_d;
    end
  end

  // Lowest-numbered pending bit wins.
  always_comb begin
    if (pending_q[0]) begin
      event_id = 2'd0;
    end else if (pending_q[1]) begin
      event_id = 2'd1;
    end else if (pending_q[2]) begin
      event_id = 2'd2;
    end else if (pending_q[3]) begin
      event_id = 2'd3;
    end else begin
      event_id = 2'd0;
    end
  end

  assign irq       = |pending_q;
  assign btn_level = btn_level_q;
  assign btn_press = btn_press_q;
  assign pending   = pending_q;

`ifdef INPUT_COND_SW_DEBOUNCE_EN
  logic [15:0] sw_cnt_q [10];
  logic [15:0] sw_cnt_d [10];
  logic [9:0]  sw_level_q, sw_level_d;

  // Switch debounce counters, same rule as buttons but active-high and pulse-free.
  always_comb begin
    sw_level_d = sw_level_q;
    for (int i = 0; i < 10; i++) begin
      sw_cnt_d[i] = 16'd0;
      if (sw_s2_q[i] == sw_level_q[i]) begin
        sw_cnt_d[i] = 16'd0;
      end else if (sw_cnt_q[i] + 16'd1 == DB_LIMIT) begin
        sw_level_d[i] = ~sw_level_q[i];
        sw_cnt_d[i]   = 16'd0;
      end else begin
        sw_cnt_d[i] = sw_cnt_q[i] + 16'd1;
      end
    end
  end

  // Switch debounce state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 10; i++) begin
        sw_cnt_q[i] <= 16'd0;
      end
      sw_level_q <= 10'b0;
    end else begin
      for (int i = 0; i < 10; i++) begin
        sw_cnt_q[i] <= sw_cnt_d[i];
      end
      sw_level_q <= sw_level_d;
    end
  end

  assign sw_sync = sw_level_q;
`else
  assign sw_sync = sw_s2_q;
`endif

endmodule
